// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Holds the default 640x480@60 timing, the line/frame total derivations and
// the sync-polarity constants used by vga_timing_gen and its testbench.
package vga_timing_pkg;

  // Default 640x480@60 timing (pixel clock ~25.175 MHz)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_COORD_W  = 10;

  // Deepest supported alignment delay for sync/active
  localparam int MAX_PIPE_DELAY = 7;

  // Sync polarity selectors
  localparam int SYNC_POL_NEG = 1;
  localparam int SYNC_POL_POS = 0;

  function automatic int h_total(input int active, input int fp,
                                 input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp,
                                 input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Pin level for a sync signal: asserted pulses drive low when active-low
  function automatic logic sync_level(input logic asserted, input logic neg);
    return asserted ^ neg;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register used to align sync/active with a pipelined
// pixel source.
// Ports:
//   clk_i     - clock
//   rst_i     - synchronous active-high reset; loads rst_val_i into every stage
//   ce_i      - shift enable; the line holds when low
//   rst_val_i - value loaded into all stages on reset
//   d_i       - input word, captured into the first stage
//   q_o       - output of the last stage (STAGES steps behind d_i)
module vga_delay_line #(
  parameter int DATA_W = 3,
  parameter int STAGES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ce_i,
  input  logic [DATA_W-1:0] rst_val_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= rst_val_i;
      end
    end else if (ce_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Owns the horizontal/vertical counters, the pixel coordinates, the active
// video flag and the per-line / per-frame strobes, and produces sync and a
// delayed active flag aligned to a pipelined pixel source.
// Ports:
//   CLK         - pixel-domain clock
//   RESET       - synchronous active-high reset
//   pix_ce      - pixel clock enable; everything advances only when high
//   x, y        - current raster position
//   active      - x/y inside the visible area, aligned with x/y
//   line_start  - high for the pixel step where x==0
//   frame_start - high for the pixel step where x==0 and y==0
//   h_sync      - horizontal sync, PIPE_DELAY steps behind x/y
//   v_sync      - vertical sync, PIPE_DELAY steps behind x/y
//   active_d    - active, PIPE_DELAY steps behind x/y
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SYNC_NEG   = SYNC_POL_NEG,
  parameter int PIPE_DELAY = 0,
  parameter int COORD_W    = DEF_COORD_W
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               pix_ce,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               active,
  output logic               line_start,
  output logic               frame_start,
  output logic               h_sync,
  output logic               v_sync,
  output logic               active_d
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if ((H_TOTAL >= (1 << COORD_W)) || (V_TOTAL >= (1 << COORD_W)) ||
      (PIPE_DELAY < 0) || (PIPE_DELAY > MAX_PIPE_DELAY)) begin : g_param_check
    $error("vga_timing_gen: totals must fit COORD_W and PIPE_DELAY must be 0..7");
  end

  localparam logic               NEG      = (SYNC_NEG != 0);
  localparam logic               SYNC_OFF = sync_level(1'b0, NEG);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  // run_q distinguishes the first step after reset, which presents (0,0)
  // instead of advancing past it.
  logic               run_q, run_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               active_q, active_nx;
  logic               line_start_q, line_start_nx;
  logic               frame_start_q, frame_start_nx;
  logic               hs_nx, vs_nx;
  logic [2:0]         dly_in, dly_out, dly_rst;

  // Next raster position for the coming pixel step
  always_comb begin
    run_d = 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (!run_q) begin
      x_d = '0;
      y_d = '0;
    end else if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + COORD_W'(1);
    end else begin
      x_d = x_q + COORD_W'(1);
    end
  end

  // Flags and sync derived from the next position so they register together
  // with x/y. v_sync only depends on y, so it can only move on the x wrap.
  always_comb begin
    active_nx      = (x_d < H_VIS) && (y_d < V_VIS);
    line_start_nx  = (x_d == '0);
    frame_start_nx = (x_d == '0) && (y_d == '0);
    hs_nx          = sync_level((x_d >= HS_BEG) && (x_d < HS_END), NEG);
    vs_nx          = sync_level((y_d >= VS_BEG) && (y_d < VS_END), NEG);
  end

  // Stage boundary: counters and aligned flags
  always_ff @(posedge CLK) begin
    if (RESET) begin
      run_q         <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pix_ce) begin
      run_q         <= run_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_nx;
      line_start_q  <= line_start_nx;
      frame_start_q <= frame_start_nx;
    end
  end

  // Stage boundary: one register aligned with x/y plus PIPE_DELAY extra steps
  assign dly_in  = {hs_nx, vs_nx, active_nx};
  assign dly_rst = {SYNC_OFF, SYNC_OFF, 1'b0};

  vga_delay_line #(
    .DATA_W (3),
    .STAGES (PIPE_DELAY + 1)
  ) u_delay (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .ce_i      (pix_ce),
    .rst_val_i (dly_rst),
    .d_i       (dly_in),
    .q_o       (dly_out)
  );

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign h_sync      = dly_out[2];
  assign v_sync      = dly_out[1];
  assign active_d    = dly_out[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default 640x480 instance with a 2-step
// alignment delay and a small active-high-sync instance for whole frames,
// both compared every cycle against a position-from-step-count model.
module tb_vga_timing_gen;

  localparam int PD = 2;
  // Small raster for whole-frame coverage
  localparam int S_HA = 40, S_HFP = 4, S_HS = 8, S_HBP = 6;
  localparam int S_VA = 20, S_VFP = 2, S_VS = 3, S_VBP = 4;
  localparam int S_PD = 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RESET = 1'b1;
  logic       pix_ce = 1'b0;
  logic [9:0] x, y;
  logic       active, line_start, frame_start, h_sync, v_sync, active_d;
  logic [5:0] sx, sy;
  logic       s_active, s_line_start, s_frame_start, s_h_sync, s_v_sync, s_active_d;

  vga_timing_gen #(.PIPE_DELAY(PD)) dut (
    .CLK(CLK), .RESET(RESET), .pix_ce(pix_ce), .x(x), .y(y), .active(active),
    .line_start(line_start), .frame_start(frame_start), .h_sync(h_sync),
    .v_sync(v_sync), .active_d(active_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_NEG(0), .PIPE_DELAY(S_PD), .COORD_W(6)
  ) dut_s (
    .CLK(CLK), .RESET(RESET), .pix_ce(pix_ce), .x(sx), .y(sy), .active(s_active),
    .line_start(s_line_start), .frame_start(s_frame_start), .h_sync(s_h_sync),
    .v_sync(s_v_sync), .active_d(s_active_d)
  );

  int checks = 0;
  int failures = 0;
  int n = 0;      // pixel steps since the last reset
  int cyc = 0;

  // Line/frame period trackers
  int   ls_rise_cyc = -1, ls_period = 0, ls_len = 0, ls_last_len = 0;
  int   fs_rise_cyc = -1, fs_period = 0;
  logic ls_prev = 1'b0, fs_prev = 1'b0;

  typedef struct {
    int x, y, act, ls, fs, hs, vs, ad;
  } exp_t;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0d expected %0d (cycle %0d, step %0d)", tag, obs, exp, cyc, n);
    end
  endtask

  // Step n>=1 shows raster position n-1; delayed outputs show position n-1-pd.
  function automatic exp_t model(input int steps, input int ha, input int hfp,
                                 input int hsw, input int hbp, input int va,
                                 input int vfp, input int vsw, input int vbp,
                                 input int neg, input int pd);
    exp_t e;
    int ht, vt, p, q, dx, dy;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    e.x = 0; e.y = 0; e.act = 0; e.ls = 0; e.fs = 0;
    e.hs = neg; e.vs = neg; e.ad = 0;
    if (steps > 0) begin
      p     = steps - 1;
      e.x   = p % ht;
      e.y   = (p / ht) % vt;
      e.act = (e.x < ha && e.y < va) ? 1 : 0;
      e.ls  = (e.x == 0) ? 1 : 0;
      e.fs  = (e.x == 0 && e.y == 0) ? 1 : 0;
      if (p >= pd) begin
        q    = p - pd;
        dx   = q % ht;
        dy   = (q / ht) % vt;
        e.ad = (dx < ha && dy < va) ? 1 : 0;
        e.hs = (dx >= ha + hfp && dx < ha + hfp + hsw) ? 1 - neg : neg;
        e.vs = (dy >= va + vfp && dy < va + vfp + vsw) ? 1 - neg : neg;
      end
    end
    return e;
  endfunction

  task automatic check_all();
    exp_t e;
    e = model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1, PD);
    check_eq("x", int'(x), e.x);
    check_eq("y", int'(y), e.y);
    check_eq("active", int'(active), e.act);
    check_eq("line_start", int'(line_start), e.ls);
    check_eq("frame_start", int'(frame_start), e.fs);
    check_eq("h_sync", int'(h_sync), e.hs);
    check_eq("v_sync", int'(v_sync), e.vs);
    check_eq("active_d", int'(active_d), e.ad);
    e = model(n, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 0, S_PD);
    check_eq("s_x", int'(sx), e.x);
    check_eq("s_y", int'(sy), e.y);
    check_eq("s_active", int'(s_active), e.act);
    check_eq("s_line_start", int'(s_line_start), e.ls);
    check_eq("s_frame_start", int'(s_frame_start), e.fs);
    check_eq("s_h_sync", int'(s_h_sync), e.hs);
    check_eq("s_v_sync", int'(s_v_sync), e.vs);
    check_eq("s_active_d", int'(s_active_d), e.ad);
  endtask

  task automatic step(input logic r, input logic ce);
    RESET  = r;
    pix_ce = ce;
    @(posedge CLK);
    #1;
    cyc++;
    if (r) n = 0;
    else if (ce) n++;
    check_all();
    if (line_start && !ls_prev) begin
      if (ls_rise_cyc >= 0) ls_period = cyc - ls_rise_cyc;
      ls_rise_cyc = cyc;
      ls_len = 0;
    end
    if (line_start) ls_len++;
    else if (ls_prev) ls_last_len = ls_len;
    ls_prev = line_start;
    if (s_frame_start && !fs_prev) begin
      if (fs_rise_cyc >= 0) fs_period = cyc - fs_rise_cyc;
      fs_rise_cyc = cyc;
    end
    fs_prev = s_frame_start;
  endtask

  task automatic reset_trackers();
    ls_rise_cyc = -1; ls_period = 0; ls_len = 0; ls_last_len = 0;
    fs_rise_cyc = -1; fs_period = 0;
  endtask

  initial begin
    // Reset held for 3 cycles with random enable
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)));

    // Continuous enable: several default lines, two small frames
    reset_trackers();
    for (int i = 0; i < 2 * 1682 + 20; i++) step(1'b0, 1'b1);
    check_eq("line_period_ce1", ls_period, 800);
    check_eq("small_frame_period", fs_period, 1682);

    // Enable toggling 1,0,1,0 from a fresh reset
    step(1'b1, 1'b0);
    reset_trackers();
    for (int i = 0; i < 3300; i++) step(1'b0, 1'(i % 2 == 0));
    check_eq("line_period_toggle", ls_period, 1600);
    check_eq("line_start_len_toggle", ls_last_len, 2);

    // Random enable with occasional resets
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0));

    // Mid-frame reset for one cycle, then restart
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
